// File: rtl/nes_mem_pkg.sv
// nes_mem_pkg: shared CPU memory-map constants and the OAM DMA state encoding.
package nes_mem_pkg;
   localparam logic [15:0] PPU_OAMDATA_ADDR = 16'h2004;
   localparam logic [15:0] OAM_DMA_ADDR     = 16'h4014;
   localparam logic [15:0] IO_BASE          = 16'h4000;
   localparam logic [15:0] EXP_BASE         = 16'h4020;
   typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_state_t;
endpackage

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: CPU bus master that stalls the CPU and copies one 256-byte page to OAMDATA.
// Optional OAM_DMA_DONE_PULSE_EN adds a one-cycle dma_done pulse on completion.
module oam_dma_ctrl
   import nes_mem_pkg::*;
#(
   parameter logic [15:0] DMA_REG_ADDR = OAM_DMA_ADDR,
   parameter logic [15:0] OAMDATA_ADDR = PPU_OAMDATA_ADDR,
   parameter int          XFER_LEN     = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_we,
   input  logic        cpu_re,
   output logic        cpu_rdy,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   output logic        bus_we,
   output logic        bus_re,
   input  logic [7:0]  bus_rdata,
   output logic        dma_busy
`ifdef OAM_DMA_DONE_PULSE_EN
   ,output logic       dma_done
`endif
);
   dma_state_t state_q, state_d;
   logic [7:0] cnt_q, cnt_d, page_q, page_d, data_q, data_d;
   logic       parity_q, idle, trig, last;
   assign idle = state_q == IDLE;
   assign trig = idle && cpu_we && cpu_addr == DMA_REG_ADDR;
   assign last = cnt_q == 8'(XFER_LEN - 1);
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      page_d  = page_q;
      data_d  = data_q;
      case (state_q)
         IDLE: if (trig) begin
            state_d = HALT;
            page_d  = cpu_wdata;
            cnt_d   = '0;
         end
         HALT:  state_d = parity_q ? ALIGN : READ;
         ALIGN: state_d = READ;
         READ: begin
            data_d  = bus_rdata;
            state_d = WRITE;
         end
         WRITE: begin
            cnt_d   = cnt_q + 8'd1;
            state_d = last ? IDLE : READ;
         end
         default: state_d = IDLE;
      endcase
   end
   // Outside IDLE the bus depends only on registered state, so CPU strobes cannot leak through
   always_comb begin
      bus_addr  = idle ? cpu_addr : state_q == WRITE ? OAMDATA_ADDR : {page_q, cnt_q};
      bus_wdata = idle ? cpu_wdata : data_q;
      bus_we    = idle ? cpu_we && !trig : state_q == WRITE;
      bus_re    = idle ? cpu_re : state_q == READ;
      cpu_rdy   = idle;
      dma_busy  = !idle;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         page_q   <= '0;
         data_q   <= '0;
         parity_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         page_q   <= page_d;
         data_q   <= data_d;
         parity_q <= !parity_q;
      end
   end
`ifdef OAM_DMA_DONE_PULSE_EN
   logic done_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) done_q <= 1'b0;
      else      done_q <= state_q == WRITE && last;
   end
   assign dma_done = done_q;
`endif
endmodule
